// File: rtl/sprite_renderer.sv
// -----------------------------------------------------------------------------
// sprite_renderer
//
// Pixel-pipeline stage placed directly in front of the sprite image ROM. For
// every incoming VGA pixel it decides whether the pixel falls inside the
// sprite rectangle. On a hit it issues a ROM read. One cycle later it takes
// the ROM word and composites it over the background using a transparent
// colour key. It also counts the opaque sprite pixels drawn in each frame.
//
// Pipeline (one pixel per cycle, 3-cycle latency):
//   edge 1 : hit test, ROM enable/address, delay video_on/bg
//   edge 2 : ROM registers its data; hit/video_on/bg delayed again
//   edge 3 : pixel_out / pixel_valid, opaque counter update
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   frame_start         1-cycle pulse in vertical blanking; latches position
//   pos_x_in, pos_y_in  sprite top-left corner to use for the next frame
//   video_on            current pixel is visible
//   pixel_x, pixel_y    current pixel coordinate
//   bg_pixel            background colour for the current pixel
//   rom_en, rom_addr    sprite ROM read request
//   rom_data            sprite ROM read data (one cycle after the request)
//   pixel_out           composited pixel
//   pixel_valid         video_on aligned with pixel_out
//   opaque_count        opaque sprite pixels drawn in the previous frame
//   count_valid         1-cycle pulse when opaque_count is updated
// -----------------------------------------------------------------------------
module sprite_renderer #(
  parameter int                SPR_W     = 128,
  parameter int                SPR_H     = 128,
  parameter int                ADDR_BITS = 14,
  parameter int                DATA_W    = 8,
  parameter int                COORD_W   = 10,
  parameter logic [DATA_W-1:0] TRANSP    = 8'hE3,
  parameter int                CNT_W     = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [COORD_W-1:0]   pos_x_in,
  input  logic [COORD_W-1:0]   pos_y_in,
  input  logic                 video_on,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic [DATA_W-1:0]    bg_pixel,
  output logic                 rom_en,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [DATA_W-1:0]    rom_data,
  output logic [DATA_W-1:0]    pixel_out,
  output logic                 pixel_valid,
  output logic [CNT_W-1:0]     opaque_count,
  output logic                 count_valid
);

  // Column bits of the row-major address; the remaining bits hold the row.
  localparam int X_BITS = $clog2(SPR_W);
  localparam int Y_BITS = ADDR_BITS - X_BITS;

  localparam logic [COORD_W:0] SPR_W_EXT = (COORD_W + 1)'(SPR_W);
  localparam logic [COORD_W:0] SPR_H_EXT = (COORD_W + 1)'(SPR_H);

  // Sprite position for the frame currently being scanned.
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;

  // Stage-1 and stage-2 side-band registers.
  logic               hit_s1;
  logic               von_s1;
  logic [DATA_W-1:0]  bg_s1;
  logic               hit_s2;
  logic               von_s2;
  logic [DATA_W-1:0]  bg_s2;

  logic [CNT_W-1:0]   run_count;

  // ---------------------------------------------------------------------------
  // Stage-1 combinational hit test and address
  // ---------------------------------------------------------------------------
  // The right/bottom edges are formed one bit wider than a coordinate. A sprite
  // hanging past the end of the coordinate range therefore clips instead of
  // wrapping back to column/row 0.
  logic [COORD_W:0]   x_end;
  logic [COORD_W:0]   y_end;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               hit;
  logic [ADDR_BITS-1:0] addr_c;

  always_comb begin
    x_end  = {1'b0, pos_x} + SPR_W_EXT;
    y_end  = {1'b0, pos_y} + SPR_H_EXT;
    dx     = pixel_x - pos_x;
    dy     = pixel_y - pos_y;
    hit    = video_on
             && (pixel_x >= pos_x) && ({1'b0, pixel_x} < x_end)
             && (pixel_y >= pos_y) && ({1'b0, pixel_y} < y_end);
    // SPR_W is a power of two, so dy*SPR_W + dx is a concatenation. The result
    // is only used on a hit, where dx < SPR_W.
    addr_c = {dy[Y_BITS-1:0], dx[X_BITS-1:0]};
  end

  // ---------------------------------------------------------------------------
  // Stage-3 combinational compositing decision
  // ---------------------------------------------------------------------------
  // rom_data is stale whenever hit_s2 is low, so it must be qualified by hit_s2.
  logic              opaque;
  logic [CNT_W-1:0]  run_next;

  always_comb begin
    opaque   = von_s2 && hit_s2 && (rom_data != TRANSP);
    run_next = (opaque && (run_count != {CNT_W{1'b1}})) ? run_count + 1'b1
                                                         : run_count;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here is a flop updated with non-blocking assignments.
  // All of them read the pre-edge values of their neighbours. This is what
  // keeps the three stages one cycle apart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: a synchronous reset clears every register, including position
      // and the running count. Any pixels in flight are dropped.
      pos_x        <= '0;
      pos_y        <= '0;
      rom_en       <= 1'b0;
      rom_addr     <= '0;
      hit_s1       <= 1'b0;
      von_s1       <= 1'b0;
      bg_s1        <= '0;
      hit_s2       <= 1'b0;
      von_s2       <= 1'b0;
      bg_s2        <= '0;
      pixel_out    <= '0;
      pixel_valid  <= 1'b0;
      run_count    <= '0;
      opaque_count <= '0;
      count_valid  <= 1'b0;
    end else begin
      // Position latch. The pixel sampled in this same cycle has already
      // used the old position above, so nothing changes mid-frame.
      if (frame_start) begin
        pos_x <= pos_x_in;
        pos_y <= pos_y_in;
      end

      // Stage 1
      rom_en <= hit;
      if (hit) begin
        rom_addr <= addr_c;
      end
      hit_s1 <= hit;
      von_s1 <= video_on;
      bg_s1  <= bg_pixel;

      // Stage 2 (the ROM registers its data on this same edge)
      hit_s2 <= hit_s1;
      von_s2 <= von_s1;
      bg_s2  <= bg_s1;

      // Stage 3
      if (!von_s2) begin
        pixel_out <= '0;
      end else if (opaque) begin
        pixel_out <= rom_data;
      end else begin
        pixel_out <= bg_s2;
      end
      pixel_valid <= von_s2;

      // Opaque counter. The frame boundary includes the increment that
      // lands in the same cycle, then the count restarts from zero.
      count_valid <= frame_start;
      if (frame_start) begin
        opaque_count <= run_next;
        run_count    <= '0;
      end else begin
        run_count    <= run_next;
      end
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_sprite_renderer
//
// Self-checking bench for sprite_renderer. A sprite ROM model (registered
// read) sits behind the DUT. A reference model predicts every output on every
// cycle. The model works from the geometric rules: a rectangle test, row-major
// offset and colour key. It places each pixel's result in a 3-deep latency
// queue and keeps a per-frame tally of opaque pixels. Directed table vectors
// and hand-written sequences cover the boundary cases.
// -----------------------------------------------------------------------------
module tb_sprite_renderer;

  localparam logic [7:0] TRANSP = 8'hE3;
  localparam int         CNT_MAX = 32767;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [9:0]  pos_x_in, pos_y_in;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic [7:0]  bg_pixel;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic [14:0] opaque_count;
  logic        count_valid;

  sprite_renderer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .pos_x_in     (pos_x_in),
    .pos_y_in     (pos_y_in),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .bg_pixel     (bg_pixel),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .opaque_count (opaque_count),
    .count_valid  (count_valid)
  );

  always #5 clk = ~clk;

  // Sprite ROM: 1-cycle registered read.
  logic [7:0] rom [16384];
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] pix;
    logic       valid;
    logic       opaque;
  } exp_t;

  exp_t        lat_q[$];       // results waiting to emerge, oldest first
  int          m_px, m_py;     // position in force for the current frame
  int          m_run;          // opaque pixels so far this frame
  logic        m_en;
  logic [13:0] m_addr;
  logic [7:0]  m_pix;
  logic        m_valid;
  logic [14:0] m_cnt;
  logic        m_cv;

  task automatic model_reset();
    exp_t b;
    b.pix = 8'h00; b.valid = 1'b0; b.opaque = 1'b0;
    lat_q.delete();
    lat_q.push_back(b);
    lat_q.push_back(b);
    m_px = 0; m_py = 0; m_run = 0;
    m_en = 1'b0; m_addr = '0; m_pix = '0; m_valid = 1'b0;
    m_cnt = '0; m_cv = 1'b0;
  endtask

  // One clock cycle: drive the inputs, predict, clock, compare.
  task automatic step(input logic rst, input logic fs,
                      input logic [9:0] pxi, input logic [9:0] pyi,
                      input logic von, input logic [9:0] x, input logic [9:0] y,
                      input logic [7:0] bg);
    exp_t e, f;
    int   ix, iy, off;
    logic h;
    rst_n = rst; frame_start = fs; pos_x_in = pxi; pos_y_in = pyi;
    video_on = von; pixel_x = x; pixel_y = y; bg_pixel = bg;

    if (!rst) begin
      model_reset();
    end else begin
      ix = int'(x); iy = int'(y);
      h  = von && ix >= m_px && ix < m_px + 128 && iy >= m_py && iy < m_py + 128;
      m_en = h;
      e.valid = von; e.opaque = 1'b0; e.pix = von ? bg : 8'h00;
      if (h) begin
        off    = (iy - m_py) * 128 + (ix - m_px);
        m_addr = 14'(off);
        if (rom[off] != TRANSP) begin
          e.opaque = 1'b1;
          e.pix    = rom[off];
        end
      end
      lat_q.push_back(e);
      f = lat_q.pop_front();
      m_pix = f.pix; m_valid = f.valid;
      m_run = (m_run + int'(f.opaque) > CNT_MAX) ? CNT_MAX : m_run + int'(f.opaque);
      m_cv  = fs;
      if (fs) begin
        m_cnt = 15'(m_run);
        m_run = 0;
        m_px  = int'(pxi);
        m_py  = int'(pyi);
      end
    end

    @(posedge clk);
    #1;
    check("rom_en",       32'(rom_en),       32'(m_en));
    check("rom_addr",     32'(rom_addr),     32'(m_addr));
    check("pixel_out",    32'(pixel_out),    32'(m_pix));
    check("pixel_valid",  32'(pixel_valid),  32'(m_valid));
    check("opaque_count", 32'(opaque_count), 32'(m_cnt));
    check("count_valid",  32'(count_valid),  32'(m_cv));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 8'h00);
  endtask

  task automatic rom_fill(input logic [7:0] v);
    for (int i = 0; i < 16384; i++) rom[i] = v;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: sprite at (100,50). Each pixel is sampled on its own,
  // then followed by two idle cycles.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [9:0]  x, y;
    logic        von;
    logic [7:0]  bg;
    logic        en;
    logic [13:0] addr;
    logic [7:0]  pix;
    logic        valid;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] v;
    int         a, placed;

    vecs[0] = '{x:100, y:50,  von:1, bg:8'h44, en:1, addr:0,     pix:8'h1C, valid:1}; // top-left
    vecs[1] = '{x:227, y:177, von:1, bg:8'h44, en:1, addr:16383, pix:8'h5A, valid:1}; // last pixel drawn
    vecs[2] = '{x:228, y:177, von:1, bg:8'h44, en:0, addr:16383, pix:8'h44, valid:1}; // one past right
    vecs[3] = '{x:227, y:178, von:1, bg:8'h21, en:0, addr:16383, pix:8'h21, valid:1}; // one past bottom
    vecs[4] = '{x:99,  y:50,  von:1, bg:8'h66, en:0, addr:16383, pix:8'h66, valid:1}; // one left of sprite
    vecs[5] = '{x:101, y:50,  von:1, bg:8'h03, en:1, addr:1,     pix:8'h03, valid:1}; // transparent word
    vecs[6] = '{x:110, y:60,  von:1, bg:8'h10, en:1, addr:1290,  pix:8'h3C, valid:1}; // interior
    vecs[7] = '{x:100, y:50,  von:0, bg:8'h77, en:0, addr:1290,  pix:8'h00, valid:0}; // blanking

    rom_fill(TRANSP);
    rom[0] = 8'h1C; rom[16383] = 8'h5A; rom[1290] = 8'h3C;

    // Reset for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'($urandom), 10'($urandom), 10'($urandom), 1'($urandom),
           10'($urandom), 10'($urandom), 8'($urandom));
    check("reset pixel_out",    32'(pixel_out),    32'h0);
    check("reset pixel_valid",  32'(pixel_valid),  32'h0);
    check("reset rom_en",       32'(rom_en),       32'h0);
    check("reset opaque_count", 32'(opaque_count), 32'h0);
    check("reset count_valid",  32'(count_valid),  32'h0);

    // Latch (100,50). That frame_start closes an empty frame.
    step(1'b1, 1'b1, 10'd100, 10'd50, 1'b0, 10'd0, 10'd0, 8'h00);
    check("first frame count", 32'(opaque_count), 32'h0);
    check("first frame cv",    32'(count_valid),  32'h1);

    foreach (vecs[i]) begin
      step(1'b1, 1'b0, 10'd0, 10'd0, vecs[i].von, vecs[i].x, vecs[i].y, vecs[i].bg);
      check($sformatf("vec%0d rom_en", i),   32'(rom_en),   32'(vecs[i].en));
      check($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      idle();
      idle();
      check($sformatf("vec%0d pixel_out", i),   32'(pixel_out),   32'(vecs[i].pix));
      check($sformatf("vec%0d pixel_valid", i), 32'(pixel_valid), 32'(vecs[i].valid));
    end

    // Three opaque pixels were drawn (0x1C, 0x5A, 0x3C); the transparent one is not counted.
    step(1'b1, 1'b1, 10'd100, 10'd50, 1'b0, 10'd0, 10'd0, 8'h00);
    check("frame count",   32'(opaque_count), 32'd3);
    check("frame cv",      32'(count_valid),  32'h1);
    // Back-to-back frame_start gives a count of 0.
    step(1'b1, 1'b1, 10'd100, 10'd50, 1'b0, 10'd0, 10'd0, 8'h00);
    check("b2b count",     32'(opaque_count), 32'd0);
    check("b2b cv",        32'(count_valid),  32'h1);
    idle();
    check("cv drops",      32'(count_valid),  32'h0);

    // pos_x_in changes without frame_start: rendering is unchanged.
    step(1'b1, 1'b0, 10'd300, 10'd300, 1'b1, 10'd100, 10'd50, 8'h44);
    check("no-latch rom_addr", 32'(rom_addr), 32'd0);
    check("no-latch rom_en",   32'(rom_en),   32'd1);
    step(1'b1, 1'b0, 10'd300, 10'd300, 1'b0, 10'd0, 10'd0, 8'h00);
    idle();
    check("no-latch pixel", 32'(pixel_out), 32'h1C);

    // Reset mid-line: in-flight pixels are dropped and position returns to (0,0).
    step(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 10'd120, 10'd70, 8'h55);
    step(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 10'd121, 10'd70, 8'h55);
    step(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 10'd122, 10'd70, 8'h55);
    check("midreset valid",  32'(pixel_valid), 32'h0);
    check("midreset rom_en", 32'(rom_en),      32'h0);
    step(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 8'h55);
    check("post-reset addr", 32'(rom_addr), 32'd0);
    check("post-reset en",   32'(rom_en),   32'd1);
    idle();
    check("flushed valid", 32'(pixel_valid), 32'h0);
    idle();
    check("post-reset pixel", 32'(pixel_out), 32'h1C);

    // Frame at (0,0): the ROM holds exactly 100 non-transparent words. A
    // 160x140 visible window covers the whole sprite.
    step(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 8'h00);
    rom_fill(TRANSP);
    placed = 0;
    while (placed < 100) begin
      a = $urandom_range(0, 16383);
      if (rom[a] == TRANSP) begin
        do v = 8'($urandom); while (v == TRANSP);
        rom[a] = v;
        placed++;
      end
    end
    step(1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 8'h00);
    for (int yy = 0; yy < 140; yy++)
      for (int xx = 0; xx < 160; xx++)
        step(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 10'(xx), 10'(yy), 8'($urandom));
    idle();
    idle();
    step(1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 8'h00);
    check("full frame count", 32'(opaque_count), 32'd100);
    check("full frame cv",    32'(count_valid),  32'h1);
    idle();
    check("full frame cv once", 32'(count_valid), 32'h0);

    // Random traffic against the model. Positions include ones near the top of
    // the coordinate range to exercise clipping; occasional resets are mixed in.
    step(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 8'h00);
    for (int i = 0; i < 16384; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? TRANSP : 8'($urandom);
    for (int i = 0; i < 6000; i++) begin
      logic       fs, rst, von;
      logic [9:0] pxi, pyi, x, y;
      fs  = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 1999) != 0);
      von = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        pxi = 10'($urandom_range(900, 1023));
        pyi = 10'($urandom_range(900, 1023));
        x   = 10'($urandom_range(880, 1023));
        y   = 10'($urandom_range(880, 1023));
      end else begin
        pxi = 10'($urandom_range(0, 250));
        pyi = 10'($urandom_range(0, 200));
        x   = 10'($urandom_range(0, 400));
        y   = 10'($urandom_range(0, 330));
      end
      step(rst, fs, pxi, pyi, von, x, y, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
